mips_bus_master_if: RTL and testbench
=====================================

MIPS_BUS_MASTER_IF -- requirements
Module: mips_bus_master_if

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 256, waitrequest-high cycles before abort; used only when the timeout feature is compiled in.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  core requests a bus transaction.
REQ-005 req_ready  output  1  block can accept a request this cycle.
REQ-006 req_write  input  1  1 = write, 0 = read.
REQ-007 req_addr  input  32  byte address from the core.
REQ-008 req_wdata  input  32  write data.
REQ-009 req_byteenable  input  4  byte lanes for the transaction.
REQ-010 resp_valid  output  1  one-cycle pulse when a transaction completes.
REQ-011 resp_rdata  output  32  read data; valid while resp_valid = 1.
REQ-012 err  output  1  sticky timeout flag.
REQ-013 address  output  32  bus word address to memory.
REQ-014 write  output  1  bus write strobe.
REQ-015 read  output  1  bus read strobe.
REQ-016 waitrequest  input  1  memory stall; 1 = hold the request.
REQ-017 writedata  output  32  bus write data.
REQ-018 byteenable  output  4  bus byte lanes.
REQ-019 readdata  input  32  bus read data.

Function
REQ-020 The FSM SHALL have three states: IDLE, BUS and RESP.
REQ-021 IDLE: req_ready = 1; all other states: req_ready = 0.
REQ-022 IDLE with req_valid = 1 and byteenable != 0:
- latch write, address, data and byteenable;
- enter BUS.
REQ-023 IDLE with req_valid = 1 and req_byteenable = 0:
- enter RESP directly, with no bus strobe;
- resp_rdata = 0.
REQ-024 Bus outputs SHALL be registered, and SHALL be driven from the first cycle in BUS.
REQ-025 address = {req_addr[31:2], 2'b00}; req_addr[1:0] is ignored.
REQ-026 Exactly one of read/write SHALL be 1 throughout BUS. Both SHALL be 0 in IDLE and RESP.
REQ-027 address, writedata and byteenable SHALL stay stable for every cycle in BUS.
REQ-028 BUS with waitrequest = 1 at a rising edge: remain in BUS.
REQ-029 BUS with waitrequest = 0 at a rising edge:
- enter RESP;
- for a read, capture readdata into resp_rdata at that same edge.
REQ-030 RESP SHALL last exactly one cycle with resp_valid = 1, then return to IDLE.
REQ-031 Minimum latency, request accepted to resp_valid = 2 cycles with zero wait states. Maximum throughput = one transaction per 3 cycles.
REQ-032 resp_rdata SHALL hold its last value until the next read completes. A write SHALL NOT change it.
REQ-033 req_valid and request fields SHALL be ignored outside IDLE.

Reset
REQ-034 reset = 1 SHALL immediately force, without waiting for clk:
- state = IDLE;
- read = 0, write = 0, resp_valid = 0;
- address = 0, writedata = 0, byteenable = 0;
- resp_rdata = 0, err = 0;
- timeout counter = 0.
REQ-035 Reset asserted during BUS SHALL abort the transaction, and no resp_valid SHALL follow.
REQ-036 The first request after reset SHALL be accepted in the first cycle reset is low.

Configuration
REQ-037 Macro BUS_MASTER_IF_TIMEOUT_EN defined:
- a counter SHALL increment each BUS cycle with waitrequest = 1;
- when the counter reaches TIMEOUT_CYCLES, read/write SHALL deassert and the FSM SHALL enter RESP;
- resp_rdata SHALL become 32'hFFFFFFFF and err SHALL set;
- err SHALL stay set until reset;
- the counter SHALL clear on entering BUS.
REQ-038 Macro undefined: no counter; BUS waits indefinitely; err SHALL be constant 0.

Verification
REQ-039 Read, addr 0x00000004, byteenable 0xF, memory word 0x00BA0015, 0 waits -> read = 1 for 1 cycle; resp_valid 2 cycles after accept; resp_rdata = 0x00BA0015.
REQ-040 Write, addr 0x00000010, wdata 0xDEADBEEF, byteenable 0x3, 3 waits -> write held 4 cycles with stable outputs; resp_valid once; a later read of that word returns the low half as 0xBEEF.
REQ-041 Read, addr 0x00000007 -> bus address = 0x00000004.
REQ-042 Request with byteenable = 0 -> no read/write strobe; resp_valid after 1 cycle; resp_rdata = 0.
REQ-043 Reset asserted during the 2nd wait cycle of a read -> read = 0 immediately; no resp_valid; next request served normally.
REQ-044 With BUS_MASTER_IF_TIMEOUT_EN, TIMEOUT_CYCLES = 8, waitrequest stuck at 1 -> abort after 8 cycles; resp_rdata = 0xFFFFFFFF; err = 1 until reset.

Source files
------------

// File: rtl/mips_bus_master_if.sv
// mips_bus_master_if
// -----------------------------------------------------------------------------
// Bridges a simple core request/response port onto an Avalon-style memory bus
// with a waitrequest stall. One transaction is in flight at a time.
//
// Optional feature: define BUS_MASTER_IF_TIMEOUT_EN to build in a stall
// timeout. After TIMEOUT_CYCLES consecutive waitrequest-high BUS cycles the
// transaction is abandoned:
//   - resp_rdata returns 32'hFFFFFFFF;
//   - the sticky err flag sets.
// Without the macro there is no timeout counter, BUS waits forever and err
// is tied to 0.
//
// Ports
//   clk, reset          system clock, asynchronous active-high reset
//   req_valid/req_ready core request handshake. A request transfers on a rising
//                       edge where both are high. req_ready is high only in
//                       IDLE. Request fields are sampled only on that edge and
//                       ignored at all other times.
//   req_write/addr/wdata/byteenable  request fields
//   resp_valid          one-cycle completion pulse
//   resp_rdata          last read data. It is held until the next read
//                       completes.
//   err                 sticky timeout flag
//   address/write/read/writedata/byteenable  registered bus outputs
//   waitrequest/readdata                     bus inputs
//   state_dbg           current FSM state encoding (IDLE=0, BUS=1, RESP=2)
// -----------------------------------------------------------------------------
module mips_bus_master_if #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_byteenable,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        err,
  output logic [31:0] address,
  output logic        write,
  output logic        read,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic [31:0] address_q, address_d;
  logic [31:0] writedata_q, writedata_d;
  logic [3:0]  byteenable_q, byteenable_d;
  logic [31:0] rdata_q, rdata_d;

`ifdef BUS_MASTER_IF_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  // Next-state and datapath logic
  always_comb begin
    state_d      = state_q;
    read_d       = read_q;
    write_d      = write_q;
    address_d    = address_q;
    writedata_d  = writedata_q;
    byteenable_d = byteenable_q;
    rdata_d      = rdata_q;
`ifdef BUS_MASTER_IF_TIMEOUT_EN
    cnt_d        = cnt_q;
    err_d        = err_q;
`endif

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_byteenable != 4'b0000) begin
            // Strobes and fields are loaded here so they are already on the
            // bus during the first BUS cycle.
            state_d      = BUS;
            read_d       = ~req_write;
            write_d      = req_write;
            address_d    = {req_addr[31:2], 2'b00};
            writedata_d  = req_wdata;
            byteenable_d = req_byteenable;
`ifdef BUS_MASTER_IF_TIMEOUT_EN
            cnt_d        = '0;
`endif
          end else begin
            // A request with no byte lanes selected completes without
            // touching the bus.
            state_d = RESP;
            rdata_d = 32'h0000_0000;
          end
        end
      end

      BUS: begin
        if (!waitrequest) begin
          state_d = RESP;
          read_d  = 1'b0;
          write_d = 1'b0;
          if (read_q) begin
            rdata_d = readdata;
          end
        end else begin
`ifdef BUS_MASTER_IF_TIMEOUT_EN
          // The abort fires on the edge where the count would reach the limit.
          if (cnt_q == TO_LIM - 1'b1) begin
            state_d = RESP;
            read_d  = 1'b0;
            write_d = 1'b0;
            rdata_d = 32'hFFFF_FFFF;
            err_d   = 1'b1;
            cnt_d   = TO_LIM;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`endif
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        read_d  = 1'b0;
        write_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      address_q    <= 32'h0000_0000;
      writedata_q  <= 32'h0000_0000;
      byteenable_q <= 4'b0000;
      rdata_q      <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      read_q       <= read_d;
      write_q      <= write_d;
      address_q    <= address_d;
      writedata_q  <= writedata_d;
      byteenable_q <= byteenable_d;
      rdata_q      <= rdata_d;
    end
  end

`ifdef BUS_MASTER_IF_TIMEOUT_EN
  // Timeout counter and sticky error flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign address    = address_q;
  assign write      = write_q;
  assign read       = read_q;
  assign writedata  = writedata_q;
  assign byteenable = byteenable_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_mips_bus_master_if.sv
module tb_mips_bus_master_if;

`ifdef BUS_MASTER_IF_TIMEOUT_EN
  localparam int unsigned TO = 8;
`else
  localparam int unsigned TO = 256;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_byteenable;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        err;
  logic [31:0] address;
  logic        write;
  logic        read;
  logic        waitrequest;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic [1:0]  state_dbg;

  mips_bus_master_if #(.TIMEOUT_CYCLES(TO)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_byteenable (req_byteenable),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .err            (err),
    .address        (address),
    .write          (write),
    .read           (read),
    .waitrequest    (waitrequest),
    .writedata      (writedata),
    .byteenable     (byteenable),
    .readdata       (readdata),
    .state_dbg      (state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // Reference model: word memory, last read data, sticky error
  logic [31:0] mem [64];
  logic [31:0] exp_rdata;
  logic        exp_err;
  int          n_cmp;
  int          n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic garbage_req();
    req_valid      = 1'($urandom_range(0, 1));
    req_write      = 1'($urandom);
    req_addr       = $urandom;
    req_wdata      = $urandom;
    req_byteenable = 4'($urandom);
  endtask

  // One complete transaction. Entered and left at #1 after a rising edge in
  // IDLE.
  task automatic do_txn(input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input int waits);
    int idx;
    idx = int'(addr[7:2]);
    req_valid      = 1'b1;
    req_write      = wr;
    req_addr       = addr;
    req_wdata      = wdata;
    req_byteenable = be;
    chk("ready_idle", {31'd0, req_ready}, 32'd1);
    chk("err_idle", {31'd0, err}, {31'd0, exp_err});
    @(posedge clk); #1;
    garbage_req();
    if (be == 4'b0000) begin
      exp_rdata = 32'h0;
    end else begin
      for (int k = 0; k <= waits; k++) begin
        waitrequest = (k < waits);
        readdata    = (k < waits) ? $urandom : mem[idx];
        chk("read_strobe", {31'd0, read}, {31'd0, ~wr});
        chk("write_strobe", {31'd0, write}, {31'd0, wr});
        chk("bus_addr", address, {addr[31:2], 2'b00});
        if (wr) chk("bus_wdata", writedata, wdata);
        chk("bus_be", {28'd0, byteenable}, {28'd0, be});
        chk("resp_in_bus", {31'd0, resp_valid}, 32'd0);
        chk("ready_in_bus", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
      end
      waitrequest = 1'($urandom);
      readdata    = $urandom;
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) mem[idx][8*b +: 8] = wdata[8*b +: 8];
      end else begin
        exp_rdata = mem[idx];
      end
    end
    chk("resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("no_strobe_resp", {30'd0, read, write}, 32'd0);
    chk("resp_rdata", resp_rdata, exp_rdata);
    chk("ready_resp", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("resp_pulse_end", {31'd0, resp_valid}, 32'd0);
    chk("ready_back", {31'd0, req_ready}, 32'd1);
    chk("rdata_held", resp_rdata, exp_rdata);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[1]    = 32'h00BA0015;
    exp_rdata = 32'h0;
    exp_err   = 1'b0;
    n_cmp     = 0;
    n_fail    = 0;
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_addr    = 32'h0;
    req_wdata   = 32'h0;
    req_byteenable = 4'h0;
    waitrequest = 1'b0;
    readdata    = 32'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Reset values
    chk("rst_strobes", {30'd0, read, write}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_address", address, 32'd0);
    chk("rst_writedata", writedata, 32'd0);
    chk("rst_byteenable", {28'd0, byteenable}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);

    // First request in the first cycle with reset low
    reset = 1'b0;
    do_txn(1'b0, 32'h0000_0004, 32'h0, 4'hF, 0);
    chk("read_word1", resp_rdata, 32'h00BA0015);

    // Write with 3 waits, then read back
    do_txn(1'b1, 32'h0000_0010, 32'hDEADBEEF, 4'h3, 3);
    do_txn(1'b0, 32'h0000_0010, 32'h0, 4'hF, 1);
    chk("readback_low", {16'd0, resp_rdata[15:0]}, 32'h0000BEEF);

    // Unaligned read address
    do_txn(1'b0, 32'h0000_0007, 32'h0, 4'hF, 0);

    // Write must not disturb resp_rdata
    do_txn(1'b1, 32'h0000_0020, 32'h12345678, 4'hF, 2);

    // Zero byteenable: no strobe, immediate response, rdata cleared
    do_txn(1'b0, 32'h0000_0008, 32'h0, 4'h0, 0);

`ifndef BUS_MASTER_IF_TIMEOUT_EN
    // Long stall without timeout: the bus just waits
    do_txn(1'b0, 32'h0000_0030, 32'h0, 4'hF, 20);
`endif

    // Random traffic
    for (int t = 0; t < 40; t++) begin
      do_txn(1'($urandom), 32'($urandom_range(0, 255)), $urandom,
             4'($urandom_range(0, 15)), $urandom_range(0, 6));
    end

    // Reset during the second wait cycle of a read
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0040;
    req_byteenable = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    waitrequest = 1'b1;
    chk("pre_rst_read", {31'd0, read}, 32'd1);
    @(posedge clk); #1;
    #2 reset = 1'b1;
    #1;
    chk("async_rst_read", {31'd0, read}, 32'd0);
    chk("async_rst_resp", {31'd0, resp_valid}, 32'd0);
    chk("async_rst_addr", address, 32'd0);
    chk("async_rst_rdata", resp_rdata, 32'd0);
    exp_rdata = 32'h0;
    exp_err   = 1'b0;
    @(posedge clk); #1;
    chk("no_resp_after_rst", {31'd0, resp_valid}, 32'd0);
    reset = 1'b0;
    waitrequest = 1'b0;
    do_txn(1'b0, 32'h0000_0004, 32'h0, 4'hF, 0);

`ifdef BUS_MASTER_IF_TIMEOUT_EN
    // Stuck waitrequest: abort after TO stalled cycles
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0050;
    req_byteenable = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    waitrequest = 1'b1;
    for (int k = 0; k < int'(TO); k++) begin
      chk("to_read_held", {31'd0, read}, 32'd1);
      chk("to_no_resp", {31'd0, resp_valid}, 32'd0);
      @(posedge clk); #1;
    end
    chk("to_resp", {31'd0, resp_valid}, 32'd1);
    chk("to_strobe_off", {31'd0, read}, 32'd0);
    chk("to_rdata", resp_rdata, 32'hFFFFFFFF);
    chk("to_err", {31'd0, err}, 32'd1);
    exp_rdata = 32'hFFFFFFFF;
    exp_err   = 1'b1;
    @(posedge clk); #1;
    waitrequest = 1'b0;
    do_txn(1'b1, 32'h0000_0054, 32'hCAFEF00D, 4'hF, 1);
    chk("err_sticky", {31'd0, err}, 32'd1);
    reset = 1'b1;
    #1;
    chk("err_cleared", {31'd0, err}, 32'd0);
    exp_err = 1'b0;
    exp_rdata = 32'h0;
    @(posedge clk); #1;
    reset = 1'b0;
`endif

    chk("err_final", {31'd0, err}, {31'd0, exp_err});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
